control_pipe: RTL and testbench
===============================

# control_pipe

Pipeline carrier for the decoded control word of the 5-stage MIPS core. It takes the signals the opcode decoder produces in ID and moves them through the ID/EX, EX/MEM and MEM/WB registers. Each downstream stage sees only the fields it uses. Hazard logic drives stall and flush inputs, which cause bubbles to be inserted, and two saturating counters record how many bubbles were inserted for performance inspection.

## Interface
Parameters:
- CNT_W, 16, width of the stall and flush bubble counters

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- enable  in  1  global advance; 0 freezes every register and both counters
- id_valid  in  1  ID holds a real instruction
- id_alu_op  in  2  decoded ALU op class (0 add, 1 sub, 2 R-type)
- id_reg_dst, id_alu_src, id_branch, id_mem_read, id_mem_write, id_mem_2_reg, id_reg_write, id_jump  in  1 each  decoded controls
- stall  in  1  load-use hazard; insert bubble into EX
- flush  in  1  branch/jump taken in MEM; squash EX and MEM contents
- ex_valid, ex_alu_op[1:0], ex_reg_dst, ex_alu_src  out  EX-stage controls
- mem_valid, mem_branch, mem_mem_read, mem_mem_write, mem_jump  out  MEM-stage controls
- wb_valid, wb_reg_write, wb_mem_2_reg  out  WB-stage controls
- stall_cnt  out  CNT_W  cycles in which a stall bubble was inserted
- flush_cnt  out  CNT_W  cycles in which a flush was applied

## Operation
- Bubble word: valid=0, all 1-bit controls 0, alu_op=2'd0. A bubble never writes the register file or memory.
- Every output comes directly from a register. There is no combinational path from input to output.
- The input path is ID → ID/EX → EX/MEM → MEM/WB. Each stage keeps all fields it forwards downstream and exposes only its own subset.
- Per-edge priority, highest first:
  - rst: all stages load the bubble word and both counters load 0.
  - enable=0: all registers and counters hold their values.
  - flush=1: ID/EX ← bubble, EX/MEM ← bubble, MEM/WB ← EX/MEM. The branch already in MEM retires normally. stall is ignored in this cycle. flush_cnt increments.
  - stall=1 (flush=0): ID/EX ← bubble, EX/MEM ← ID/EX, MEM/WB ← EX/MEM. stall_cnt increments.
  - otherwise: ID/EX ← ID inputs (valid=id_valid), then normal shift.
- When id_valid=0 and there is no stall or flush, the ID control inputs are still captured. Only the valid bit is forced to 0, and the WB/MEM write enables are gated with valid.
- Counters:
  - Unsigned, saturating at 2^CNT_W−1. They never wrap.
  - Cleared only by rst.

## Timing
- Latency: ID inputs sampled at edge N appear on EX outputs after edge N, on MEM outputs after N+1, and on WB outputs after N+2.
- A stall costs one EX bubble per asserted cycle. The upstream decoder is expected to hold its ID inputs meanwhile; this block does not buffer them.
- A flush asserted for one cycle leaves bubbles in EX (after that edge) and in MEM (after that edge). WB receives the flushing branch.
- Reset value of every output is 0, including all valid bits and both counters.
- Reset asserted mid-stream discards all in-flight controls on the next edge. No write enable may be 1 in the cycle after the reset edge.

## Structure
- Shared package (cpu_pkg):
  - ALU op class constants (ADD_OPCODE=0, SUB_OPCODE=1, R_TYPE_OPCODE=2).
  - Control-word field widths.
  - Bubble constant.
- Sub-module ctrl_stage_reg:
  - One parameterised-width pipeline register with en and clr inputs, where clr loads the bubble.
  - Instantiated three times with widths matching each stage's carried fields.
- Counters live in the top level, written as one saturating-increment idiom instantiated twice.

## Test plan
- Reset then R-type: rst for 2 cycles, then id_valid=1, reg_write=1, reg_dst=1, alu_op=2. Expect ex_alu_op=2 and ex_reg_dst=1 after 1 edge, wb_reg_write=1 after 3 edges, and all outputs 0 during reset.
- Load-use stall: lw, then stall=1 for 1 cycle. Expect ex_valid=0 for exactly one cycle, lw mem_mem_read=1 continuing to MEM, and stall_cnt=1.
- Flush: branch in MEM with flush=1 and stall=1 together. Expect ex_valid=0, mem_valid=0, wb_valid=1 on the next cycle, flush_cnt=1, and stall_cnt unchanged.
- Freeze: enable=0 for 5 cycles while a sw is in MEM. mem_mem_write must stay 1 and unchanged, and the counters must hold.
- Saturation: with CNT_W=3, hold stall=1 for 10 cycles. stall_cnt reaches 7 and stays at 7.
- Reset mid-stream: three valid instructions in flight, then rst=1 for one edge. All valid bits and write enables read 0 on the following cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared control-word definitions for the MIPS pipeline: ALU op classes,
// per-stage control field layouts and their bubble (no-op) encodings.
package cpu_pkg;

  localparam logic [1:0] ADD_OPCODE    = 2'd0;
  localparam logic [1:0] SUB_OPCODE    = 2'd1;
  localparam logic [1:0] R_TYPE_OPCODE = 2'd2;

  localparam int ALU_OP_W = 2;

  typedef struct packed {
    logic                valid;
    logic [ALU_OP_W-1:0] alu_op;
    logic                reg_dst;
    logic                alu_src;
    logic                branch;
    logic                mem_read;
    logic                mem_write;
    logic                mem_2_reg;
    logic                reg_write;
    logic                jump;
  } id_ex_t;

  typedef struct packed {
    logic valid;
    logic branch;
    logic mem_read;
    logic mem_write;
    logic jump;
    logic mem_2_reg;
    logic reg_write;
  } ex_mem_t;

  typedef struct packed {
    logic valid;
    logic reg_write;
    logic mem_2_reg;
  } mem_wb_t;

  localparam int ID_EX_W  = $bits(id_ex_t);
  localparam int EX_MEM_W = $bits(ex_mem_t);
  localparam int MEM_WB_W = $bits(mem_wb_t);

  // A bubble is all-zero: invalid, no writes, alu_op = add.
  localparam id_ex_t  ID_EX_BUBBLE  = '0;
  localparam ex_mem_t EX_MEM_BUBBLE = '0;
  localparam mem_wb_t MEM_WB_BUBBLE = '0;

endpackage

// File: rtl/ctrl_stage_reg.sv
// One pipeline register for a control word. en=0 holds; clr loads the
// bubble when advancing; rst loads the bubble unconditionally.
module ctrl_stage_reg #(
  parameter int           W      = 8,
  parameter logic [W-1:0] BUBBLE = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] word_q;
  logic [W-1:0] word_d;

  always_comb begin
    word_d = word_q;
    if (en) begin
      word_d = clr ? BUBBLE : d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_q <= BUBBLE;
    end else begin
      word_q <= word_d;
    end
  end

  assign q = word_q;

endmodule

// File: rtl/control_pipe.sv
// Carries decoded control from ID through ID/EX, EX/MEM and MEM/WB with
// stall/flush bubble insertion and saturating bubble counters.
module control_pipe
  import cpu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             id_valid,
  input  logic [1:0]       id_alu_op,
  input  logic             id_reg_dst,
  input  logic             id_alu_src,
  input  logic             id_branch,
  input  logic             id_mem_read,
  input  logic             id_mem_write,
  input  logic             id_mem_2_reg,
  input  logic             id_reg_write,
  input  logic             id_jump,
  input  logic             stall,
  input  logic             flush,
  output logic             ex_valid,
  output logic [1:0]       ex_alu_op,
  output logic             ex_reg_dst,
  output logic             ex_alu_src,
  output logic             mem_valid,
  output logic             mem_branch,
  output logic             mem_mem_read,
  output logic             mem_mem_write,
  output logic             mem_jump,
  output logic             wb_valid,
  output logic             wb_reg_write,
  output logic             wb_mem_2_reg,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  id_ex_t  id_word, id_ex_q;
  ex_mem_t ex_mem_d, ex_mem_q;
  mem_wb_t mem_wb_d, mem_wb_q;

  // Non-valid slots keep their decoded fields but never carry a write enable.
  always_comb begin
    id_word           = ID_EX_BUBBLE;
    id_word.valid     = id_valid;
    id_word.alu_op    = id_alu_op;
    id_word.reg_dst   = id_reg_dst;
    id_word.alu_src   = id_alu_src;
    id_word.branch    = id_branch;
    id_word.mem_read  = id_mem_read;
    id_word.mem_write = id_mem_write & id_valid;
    id_word.mem_2_reg = id_mem_2_reg;
    id_word.reg_write = id_reg_write & id_valid;
    id_word.jump      = id_jump;
  end

  always_comb begin
    ex_mem_d           = EX_MEM_BUBBLE;
    ex_mem_d.valid     = id_ex_q.valid;
    ex_mem_d.branch    = id_ex_q.branch;
    ex_mem_d.mem_read  = id_ex_q.mem_read;
    ex_mem_d.mem_write = id_ex_q.mem_write;
    ex_mem_d.jump      = id_ex_q.jump;
    ex_mem_d.mem_2_reg = id_ex_q.mem_2_reg;
    ex_mem_d.reg_write = id_ex_q.reg_write;

    mem_wb_d           = MEM_WB_BUBBLE;
    mem_wb_d.valid     = ex_mem_q.valid;
    mem_wb_d.reg_write = ex_mem_q.reg_write;
    mem_wb_d.mem_2_reg = ex_mem_q.mem_2_reg;
  end

  ctrl_stage_reg #(.W(ID_EX_W), .BUBBLE(ID_EX_BUBBLE)) u_id_ex (
    .clk(clk), .rst(rst), .en(enable), .clr(stall | flush),
    .d(id_word), .q(id_ex_q)
  );

  // The branch in MEM retires on a flush; only younger slots are squashed.
  ctrl_stage_reg #(.W(EX_MEM_W), .BUBBLE(EX_MEM_BUBBLE)) u_ex_mem (
    .clk(clk), .rst(rst), .en(enable), .clr(flush),
    .d(ex_mem_d), .q(ex_mem_q)
  );

  ctrl_stage_reg #(.W(MEM_WB_W), .BUBBLE(MEM_WB_BUBBLE)) u_mem_wb (
    .clk(clk), .rst(rst), .en(enable), .clr(1'b0),
    .d(mem_wb_d), .q(mem_wb_q)
  );

  assign ex_valid      = id_ex_q.valid;
  assign ex_alu_op     = id_ex_q.alu_op;
  assign ex_reg_dst    = id_ex_q.reg_dst;
  assign ex_alu_src    = id_ex_q.alu_src;
  assign mem_valid     = ex_mem_q.valid;
  assign mem_branch    = ex_mem_q.branch;
  assign mem_mem_read  = ex_mem_q.mem_read;
  assign mem_mem_write = ex_mem_q.mem_write;
  assign mem_jump      = ex_mem_q.jump;
  assign wb_valid      = mem_wb_q.valid;
  assign wb_reg_write  = mem_wb_q.reg_write;
  assign wb_mem_2_reg  = mem_wb_q.mem_2_reg;

  // Index 0 counts stall bubbles, index 1 flushes; flush masks a stall.
  logic [1:0] cnt_inc;
  assign cnt_inc = {flush, stall & ~flush};

  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (enable && cnt_inc[gi] && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end
  end

  assign stall_cnt = g_cnt[0].cnt_q;
  assign flush_cnt = g_cnt[1].cnt_q;

endmodule

// File: tb/tb_control_pipe.sv
// Directed bench for control_pipe; expected stage words are hand-derived.
module tb_control_pipe;

  localparam int CNT_W = 3;

  logic clk = 1'b0;
  logic rst, enable, id_valid, stall, flush;
  logic [1:0] id_alu_op;
  logic id_reg_dst, id_alu_src, id_branch, id_mem_read, id_mem_write;
  logic id_mem_2_reg, id_reg_write, id_jump;
  logic ex_valid, ex_reg_dst, ex_alu_src;
  logic [1:0] ex_alu_op;
  logic mem_valid, mem_branch, mem_mem_read, mem_mem_write, mem_jump;
  logic wb_valid, wb_reg_write, wb_mem_2_reg;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  control_pipe #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .id_valid(id_valid), .id_alu_op(id_alu_op), .id_reg_dst(id_reg_dst),
    .id_alu_src(id_alu_src), .id_branch(id_branch), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_mem_2_reg(id_mem_2_reg),
    .id_reg_write(id_reg_write), .id_jump(id_jump),
    .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_alu_op(ex_alu_op), .ex_reg_dst(ex_reg_dst),
    .ex_alu_src(ex_alu_src),
    .mem_valid(mem_valid), .mem_branch(mem_branch), .mem_mem_read(mem_mem_read),
    .mem_mem_write(mem_mem_write), .mem_jump(mem_jump),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_mem_2_reg(wb_mem_2_reg),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // Packed views: ex={valid,alu_op,reg_dst,alu_src}
  // mem={valid,branch,mem_read,mem_write,jump}  wb={valid,reg_write,mem_2_reg}
  wire [4:0] ex_w  = {ex_valid, ex_alu_op, ex_reg_dst, ex_alu_src};
  wire [4:0] mem_w = {mem_valid, mem_branch, mem_mem_read, mem_mem_write, mem_jump};
  wire [2:0] wb_w  = {wb_valid, wb_reg_write, wb_mem_2_reg};

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input string what);
    @(posedge clk);
    #1;
    $display("t=%0t %s ex=%b mem=%b wb=%b stall_cnt=%0d flush_cnt=%0d",
             $time, what, ex_w, mem_w, wb_w, stall_cnt, flush_cnt);
  endtask

  task automatic drive_id(input logic v, input logic [1:0] op, input logic rd,
                          input logic as, input logic br, input logic mr,
                          input logic mw, input logic m2r, input logic rw,
                          input logic jp);
    id_valid = v; id_alu_op = op; id_reg_dst = rd; id_alu_src = as;
    id_branch = br; id_mem_read = mr; id_mem_write = mw;
    id_mem_2_reg = m2r; id_reg_write = rw; id_jump = jp;
  endtask

  task automatic id_idle();
    drive_id(0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; stall = 1'b0; flush = 1'b0;
    id_idle();

    // Reset
    step("reset");
    step("reset");
    check("rst_ex", ex_w, 5'b00000);
    check("rst_mem", mem_w, 5'b00000);
    check("rst_wb", wb_w, 3'b000);
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_flush_cnt", flush_cnt, 0);
    rst = 1'b0;

    // R-type travels down the pipe
    drive_id(1, 2'd2, 1, 0, 0, 0, 0, 0, 1, 0);
    step("rtype_ex");
    check("rtype_ex", ex_w, 5'b11010);
    id_idle();
    step("rtype_mem");
    check("rtype_mem", mem_w, 5'b10000);
    check("rtype_ex_after", ex_w, 5'b00000);
    step("rtype_wb");
    check("rtype_wb", wb_w, 3'b110);

    // Invalid slot keeps fields but no write enables
    drive_id(0, 2'd1, 1, 0, 0, 0, 1, 0, 1, 0);
    step("inval_ex");
    check("inval_ex", ex_w, 5'b00110);
    id_idle();
    step("inval_mem");
    check("inval_mem", mem_w, 5'b00000);
    step("inval_wb");
    check("inval_wb", wb_w, 3'b000);

    // Load-use stall
    drive_id(1, 2'd0, 0, 1, 0, 1, 0, 1, 1, 0);
    step("lw_ex");
    check("lw_ex", ex_w, 5'b10001);
    drive_id(1, 2'd2, 1, 0, 0, 0, 0, 0, 1, 0);
    stall = 1'b1;
    step("stall");
    check("stall_ex_bubble", ex_w, 5'b00000);
    check("stall_lw_mem", mem_w, 5'b10100);
    check("stall_cnt_1", stall_cnt, 1);
    stall = 1'b0;
    step("after_stall");
    check("held_add_ex", ex_w, 5'b11010);
    check("bubble_mem", mem_w, 5'b00000);
    check("lw_wb", wb_w, 3'b111);
    check("stall_cnt_hold", stall_cnt, 1);
    id_idle();
    step("drain");

    // Flush with a coincident stall
    drive_id(1, 2'd1, 0, 0, 1, 0, 0, 0, 0, 0);
    step("br_ex");
    check("br_ex", ex_w, 5'b10100);
    drive_id(1, 2'd0, 0, 1, 0, 0, 0, 0, 1, 0);
    step("br_mem");
    check("br_mem", mem_w, 5'b11000);
    check("younger_ex", ex_w, 5'b10001);
    drive_id(1, 2'd2, 1, 0, 0, 0, 0, 0, 1, 0);
    flush = 1'b1; stall = 1'b1;
    step("flush");
    check("flush_ex", ex_w, 5'b00000);
    check("flush_mem", mem_w, 5'b00000);
    check("flush_wb_branch", wb_w, 3'b100);
    check("flush_cnt_1", flush_cnt, 1);
    check("flush_stall_cnt", stall_cnt, 1);
    flush = 1'b0; stall = 1'b0;
    id_idle();
    step("after_flush");
    check("after_flush_wb", wb_w, 3'b000);

    // Freeze with a store in MEM
    drive_id(1, 2'd0, 0, 1, 0, 0, 1, 0, 0, 0);
    step("sw_ex");
    id_idle();
    step("sw_mem");
    check("sw_mem", mem_w, 5'b10010);
    enable = 1'b0; stall = 1'b1;
    drive_id(1, 2'd2, 1, 1, 1, 1, 1, 1, 1, 1);
    for (int i = 0; i < 5; i++) begin
      step("freeze");
      check("freeze_mem", mem_w, 5'b10010);
      check("freeze_ex", ex_w, 5'b00000);
      check("freeze_stall_cnt", stall_cnt, 1);
      check("freeze_flush_cnt", flush_cnt, 1);
    end
    enable = 1'b1; stall = 1'b0;
    id_idle();
    step("unfreeze");
    check("sw_wb", wb_w, 3'b100);
    check("unfreeze_mem", mem_w, 5'b00000);

    // Saturation of stall_cnt (3 bits)
    stall = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step("sat");
      check("sat_stall_cnt", stall_cnt, (1 + i > 7) ? 7 : 1 + i);
    end
    stall = 1'b0;
    step("sat_done");
    check("sat_hold", stall_cnt, 7);
    check("sat_flush_cnt", flush_cnt, 1);

    // Reset mid-stream
    drive_id(1, 2'd0, 0, 1, 0, 1, 0, 1, 1, 0);
    step("ms_lw");
    drive_id(1, 2'd0, 0, 1, 0, 0, 1, 0, 0, 0);
    step("ms_sw");
    drive_id(1, 2'd2, 1, 0, 0, 0, 0, 0, 1, 0);
    step("ms_add");
    check("ms_pre_wb", wb_w, 3'b111);
    check("ms_pre_mem", mem_w, 5'b10010);
    check("ms_pre_ex", ex_w, 5'b11010);
    rst = 1'b1;
    step("ms_rst");
    check("ms_rst_ex", ex_w, 5'b00000);
    check("ms_rst_mem", mem_w, 5'b00000);
    check("ms_rst_wb", wb_w, 3'b000);
    check("ms_rst_stall_cnt", stall_cnt, 0);
    check("ms_rst_flush_cnt", flush_cnt, 0);
    rst = 1'b0;
    id_idle();
    step("ms_after");
    check("ms_after_mem", mem_w, 5'b00000);
    check("ms_after_wb", wb_w, 3'b000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
